// File: rtl/sdu_accum_ram.sv
// Sample accumulation buffer: simple dual-port RAM with combinational read and
// synchronous write, so read-modify-write at one address completes in a cycle.
module sdu_accum_ram #(
  parameter int DW    = 32,
  parameter int AW    = 16,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          rd_in_range;
  logic          wr_in_range;

  assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[rd_addr[IW-1:0]];
    end
  end

  // Array carries no reset so it maps onto RAM; reset_n only gates the write strobe.
  always_ff @(posedge clk) begin
    if (wr_en && reset_n && wr_in_range) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sdu_accum_ram.sv
// Self-checking bench for sdu_accum_ram: directed scenarios plus randomized
// traffic against an associative-array model, on a full-size and a short instance.
module tb_sdu_accum_ram;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rd_addr, wr_addr;
  logic [31:0] rd_data, wr_data;
  logic        wr_en;
  logic [3:0]  s_rd_addr, s_wr_addr;
  logic [31:0] s_rd_data, s_wr_data;
  logic        s_wr_en;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] big_model [logic [15:0]];
  logic [31:0] small_model [8];
  logic        small_valid [8];

  always #5 clk = ~clk;

  sdu_accum_ram #(.DW(32), .AW(16)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  sdu_accum_ram #(.DW(32), .AW(4), .DEPTH(8)) dut_small (
    .clk(clk), .reset_n(reset_n), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic big_write(input logic [15:0] a, input logic [31:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    if (reset_n) big_model[a] = d;
    wr_en = 1'b0;
  endtask

  task automatic big_read(input string tag, input logic [15:0] a);
    rd_addr = a; #1;
    check(tag, rd_data, big_model[a]);
  endtask

  task automatic small_write(input logic [3:0] a, input logic [31:0] d);
    s_wr_addr = a; s_wr_data = d; s_wr_en = 1'b1;
    @(posedge clk); #1;
    if (reset_n && a < 8) begin
      small_model[a[2:0]] = d;
      small_valid[a[2:0]] = 1'b1;
    end
    s_wr_en = 1'b0;
  endtask

  task automatic small_read(input string tag, input logic [3:0] a);
    s_rd_addr = a; #1;
    if (a >= 8) check(tag, s_rd_data, 32'h0);
    else if (small_valid[a[2:0]]) check(tag, s_rd_data, small_model[a[2:0]]);
  endtask

  initial begin
    logic [31:0] inc [4];
    logic [31:0] samp [4];
    logic [15:0] pool [48];
    inc  = '{32'd1, 32'd2, 32'd3, 32'd4};
    samp = '{32'd10, 32'd20, 32'd30, 32'hFFFF_FFFF};
    for (int i = 0; i < 32; i++) pool[i] = 16'(i);
    for (int i = 0; i < 16; i++) pool[32 + i] = 16'hFFF0 + 16'(i);
    for (int i = 0; i < 8; i++) small_valid[i] = 1'b0;

    reset_n = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    small_read("reset_oor_read", 4'd12);
    reset_n = 1'b1;

    // Basic write/read, including top address
    big_write(16'h0000, 32'h0000_0005);
    big_write(16'h0001, 32'hFFFF_FFFE);
    big_write(16'hFFFF, 32'h1234_5678);
    rd_addr = 16'h0000; #1; check("basic_0", rd_data, 32'd5);
    rd_addr = 16'h0001; #1; check("basic_1", rd_data, 32'hFFFF_FFFE);
    rd_addr = 16'hFFFF; #1; check("basic_ffff", rd_data, 32'h1234_5678);

    // Accumulate loop: second pass feeds rd_data + increment back in
    for (int i = 0; i < 4; i++) big_write(16'(i), samp[i]);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 16'(i); wr_addr = 16'(i); #1;
      wr_data = rd_data + inc[i]; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      big_model[16'(i)] = samp[i] + inc[i];
    end
    rd_addr = 16'd0; #1; check("accum_0", rd_data, 32'd11);
    rd_addr = 16'd1; #1; check("accum_1", rd_data, 32'd22);
    rd_addr = 16'd2; #1; check("accum_2", rd_data, 32'd33);
    rd_addr = 16'd3; #1; check("accum_3", rd_data, 32'd3);

    // Read during write, same address
    big_write(16'd7, 32'd100);
    rd_addr = 16'd7; wr_addr = 16'd7; wr_data = 32'd200; wr_en = 1'b1; #1;
    check("rdw_before", rd_data, 32'd100);
    @(posedge clk); #1;
    wr_en = 1'b0; big_model[16'd7] = 32'd200;
    check("rdw_after", rd_data, 32'd200);

    // Reset asserted mid-burst suppresses the pending write
    big_write(16'd2, 32'hAA);
    wr_addr = 16'd2; wr_data = 32'hBB; wr_en = 1'b1; rd_addr = 16'd2;
    #2 reset_n = 1'b0;
    @(posedge clk); #1;
    check("reset_write_blocked", rd_data, 32'hAA);
    @(posedge clk); #1;
    check("reset_read_live", rd_data, 32'hAA);
    wr_en = 1'b0;
    reset_n = 1'b1;
    big_write(16'd2, 32'hCC);
    big_read("post_reset_write", 16'd2);
    check("post_reset_const", rd_data, 32'hCC);

    // Out-of-range on the short instance
    small_write(4'd1, 32'h11);
    small_write(4'd9, 32'h55);
    s_rd_addr = 4'd1; #1; check("oor_no_alias", s_rd_data, 32'h11);
    s_rd_addr = 4'd9; #1; check("oor_read_9", s_rd_data, 32'h0);
    s_rd_addr = 4'd12; #1; check("oor_read_12", s_rd_data, 32'h0);

    // Back-to-back writes then playback sweep
    for (int i = 0; i < 16; i++) big_write(16'(i), 32'(i));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 16'(i); #1;
      check("playback", rd_data, 32'(i));
      @(posedge clk); #1;
    end

    // Randomized traffic, concurrent read and write each cycle
    for (int n = 0; n < 300; n++) begin
      logic [15:0] ra, wa;
      logic [31:0] d;
      logic        en;
      logic [3:0]  sra, swa;
      logic        sen;
      ra  = pool[$urandom_range(47)];
      wa  = ($urandom_range(3) == 0) ? ra : pool[$urandom_range(47)];
      d   = $urandom;
      en  = 1'($urandom_range(1));
      sra = 4'($urandom_range(15));
      swa = 4'($urandom_range(15));
      sen = 1'($urandom_range(1));
      rd_addr = ra; wr_addr = wa; wr_data = d; wr_en = en;
      s_rd_addr = sra; s_wr_addr = swa; s_wr_data = ~d; s_wr_en = sen;
      #1;
      if (big_model.exists(ra)) check("rand_pre", rd_data, big_model[ra]);
      if (sra >= 8) check("rand_small_oor", s_rd_data, 32'h0);
      else if (small_valid[sra[2:0]]) check("rand_small_pre", s_rd_data, small_model[sra[2:0]]);
      @(posedge clk); #1;
      if (en) big_model[wa] = d;
      if (sen && swa < 8) begin
        small_model[swa[2:0]] = ~d;
        small_valid[swa[2:0]] = 1'b1;
      end
      if (big_model.exists(ra)) check("rand_post", rd_data, big_model[ra]);
      if (sra < 8 && small_valid[sra[2:0]]) check("rand_small_post", s_rd_data, small_model[sra[2:0]]);
    end
    wr_en = 1'b0; s_wr_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
